// File: rtl/hazard_pkg.sv
// Shared decode constants and sequencer state encoding for the hazard unit.
package hazard_pkg;

   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RIMM   = 7'b0010011;
   localparam logic [6:0] OP_HALT   = 7'b1111111;

   localparam logic [1:0] PC_SRC_REDIRECT = 2'b01;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUL_WAIT = 2'd1,
      HALTED   = 2'd2
   } state_t;

endpackage

// File: rtl/mul_stall_counter.sv
// Down-counter tracking the remaining multiply stall cycles; flags when it reaches zero.
module mul_stall_counter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       dec,
   input  logic [3:0] load_val,
   output logic       cnt_zero
);

   logic [3:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= 4'd0;
      else if (load)
         cnt <= load_val;
      else if (dec)
         cnt <= cnt - 4'd1;
   end

   assign cnt_zero = (cnt == 4'd0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline sequencer: chooses advance, hold or flush each cycle for load-use,
// multiply occupancy, decode redirects and halt; owns PC/IF/ID/ID/EX enables.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] id_inst,
   input  logic [1:0]  id_pc_src,
   input  logic        ex_mem_read,
   input  logic        ex_reg_write,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_mul,
   output logic        control_sel,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        idex_write,
   output logic        ifid_flush,
   output logic        halted
);

   localparam logic       MUL_EN     = (MUL_LAT > 1);
   localparam logic [3:0] MUL_RELOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

   state_t     state, next_state;
   logic       cnt_load, cnt_dec, cnt_zero;
   logic       apply_rules;
   logic [4:0] rs1, rs2;
   logic [6:0] opcode;
   logic       uses_rs1, uses_rs2, load_use, redirect, is_halt;
   logic       unused_bits;

   assign rs1    = id_inst[19:15];
   assign rs2    = id_inst[24:20];
   assign opcode = id_inst[6:0];

   // Fields not needed for hazard decisions.
   assign unused_bits = ^{id_inst[31:25], id_inst[14:7], ex_reg_write};

   assign uses_rs1 = (opcode != OP_JAL) && (opcode != OP_HALT);
   assign uses_rs2 = (opcode == OP_RTYPE) || (opcode == OP_BRANCH) || (opcode == OP_STORE);
   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
   assign is_halt  = (opcode == OP_HALT);
   assign redirect = (id_pc_src == PC_SRC_REDIRECT) && !is_halt;

   mul_stall_counter u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (MUL_RELOAD),
      .cnt_zero (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= RUN;
      else
         state <= next_state;
   end

   always_comb begin
      control_sel = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      ifid_flush  = 1'b0;
      halted      = 1'b0;
      next_state  = state;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      apply_rules = 1'b0;

      case (state)
         RUN: begin
            if (MUL_EN && ex_is_mul) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_write = 1'b0;
               cnt_load   = 1'b1;
               next_state = MUL_WAIT;
            end else begin
               apply_rules = 1'b1;
            end
         end
         MUL_WAIT: begin
            // At cnt==0 the same mul is still in EX, so ex_is_mul must not retrigger.
            if (!cnt_zero) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_write = 1'b0;
               cnt_dec    = 1'b1;
            end else begin
               apply_rules = 1'b1;
               next_state  = RUN;
            end
         end
         HALTED: begin
            control_sel = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            halted      = 1'b1;
         end
         default: next_state = RUN;
      endcase

      // Load-use outranks redirect: the branch compare needs the loaded value.
      if (apply_rules) begin
         if (load_use) begin
            control_sel = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
         end else if (is_halt) begin
            control_sel = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            next_state  = HALTED;
         end else if (redirect) begin
            ifid_flush = 1'b1;
         end
      end

      if (!reset_n) begin
         control_sel = 1'b1;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         ifid_flush  = 1'b0;
         halted      = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MUL_LAT=3 and MUL_LAT=1 instances side by side.
module tb_hazard_unit;

   // Output vector order: {control_sel, pc_write, ifid_write, idex_write, ifid_flush, halted}
   localparam logic [5:0] RUN_OK = 6'b011100;
   localparam logic [5:0] MUL_ST = 6'b000000;
   localparam logic [5:0] LU_ST  = 6'b100100;
   localparam logic [5:0] HLT_1  = 6'b100100;
   localparam logic [5:0] FLUSH  = 6'b011110;
   localparam logic [5:0] HLT_O  = 6'b100101;
   localparam logic [5:0] RST_O  = 6'b100000;

   logic        clk;
   logic        reset_n;
   logic [31:0] id_inst;
   logic [1:0]  id_pc_src;
   logic        ex_mem_read;
   logic        ex_reg_write;
   logic [4:0]  ex_rd;
   logic        ex_is_mul;

   logic cs3, pcw3, ifw3, idw3, fl3, h3;
   logic cs1, pcw1, ifw1, idw1, fl1, h1;
   logic [5:0] o3, o1;

   int n_checks = 0;
   int n_errors = 0;

   assign o3 = {cs3, pcw3, ifw3, idw3, fl3, h3};
   assign o1 = {cs1, pcw1, ifw1, idw1, fl1, h1};

   hazard_unit #(.MUL_LAT(3)) dut (
      .clk(clk), .reset_n(reset_n), .id_inst(id_inst), .id_pc_src(id_pc_src),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .ex_is_mul(ex_is_mul), .control_sel(cs3), .pc_write(pcw3), .ifid_write(ifw3),
      .idex_write(idw3), .ifid_flush(fl3), .halted(h3)
   );

   hazard_unit #(.MUL_LAT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .id_inst(id_inst), .id_pc_src(id_pc_src),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .ex_is_mul(ex_is_mul), .control_sel(cs1), .pc_write(pcw1), .ifid_write(ifw1),
      .idex_write(idw1), .ifid_flush(fl1), .halted(h1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2);
      return {7'd0, r2, r1, 3'd0, 5'd0, op};
   endfunction

   task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Sample both instances at the falling edge, then advance past the next rising edge.
   task automatic cyc(input string tag, input logic [5:0] e3, input logic [5:0] e1);
      @(negedge clk);
      check({tag, "_L3"}, o3, e3);
      check({tag, "_L1"}, o1, e1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_inst     = mk(7'b0010011, 5'd0, 5'd0);
      id_pc_src   = 2'b00;
      ex_mem_read = 1'b0;
      ex_rd       = 5'd0;
      ex_is_mul   = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      ex_reg_write = 1'b1;
      idle();
      #2;
      check("reset_L3", o3, RST_O);
      check("reset_L1", o1, RST_O);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #2;
      cyc("idle", RUN_OK, RUN_OK);

      // Load-use on rs1: exactly one stall cycle
      ex_mem_read = 1'b1; ex_rd = 5'd5;
      id_inst = mk(7'b0110011, 5'd5, 5'd7);
      cyc("lu_rs1", LU_ST, LU_ST);
      ex_mem_read = 1'b0;
      cyc("lu_after", RUN_OK, RUN_OK);

      // No stall cases: rd=0, I-type rs2 field, jal rs1 field
      ex_mem_read = 1'b1; ex_rd = 5'd0;
      id_inst = mk(7'b0110011, 5'd0, 5'd7);
      cyc("lu_x0", RUN_OK, RUN_OK);
      ex_rd = 5'd5;
      id_inst = mk(7'b0010011, 5'd3, 5'd5);
      cyc("lu_imm_rs2", RUN_OK, RUN_OK);
      id_inst = mk(7'b1101111, 5'd5, 5'd5);
      cyc("lu_jal", RUN_OK, RUN_OK);
      id_inst = mk(7'b0100011, 5'd3, 5'd5);
      cyc("lu_store_rs2", LU_ST, LU_ST);
      idle();

      // Back-to-back muls: 2 + 2 stall cycles for MUL_LAT=3, none for MUL_LAT=1
      ex_is_mul = 1'b1;
      cyc("mul_a0", MUL_ST, RUN_OK);
      cyc("mul_a1", MUL_ST, RUN_OK);
      cyc("mul_a2", RUN_OK, RUN_OK);
      cyc("mul_b0", MUL_ST, RUN_OK);
      cyc("mul_b1", MUL_ST, RUN_OK);
      cyc("mul_b2", RUN_OK, RUN_OK);
      ex_is_mul = 1'b0;
      cyc("mul_done", RUN_OK, RUN_OK);

      // Redirect
      id_inst = mk(7'b1100011, 5'd1, 5'd2); id_pc_src = 2'b01;
      cyc("redir", FLUSH, FLUSH);
      idle();
      cyc("redir_after", RUN_OK, RUN_OK);

      // Branch with load-use on rs2: stall, then flush
      id_inst = mk(7'b1100011, 5'd1, 5'd5); id_pc_src = 2'b01;
      ex_mem_read = 1'b1; ex_rd = 5'd5;
      cyc("br_lu", LU_ST, LU_ST);
      ex_mem_read = 1'b0;
      cyc("br_flush", FLUSH, FLUSH);
      idle();

      // Mul with simultaneous load-use and redirect
      ex_is_mul = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
      id_inst = mk(7'b1100011, 5'd1, 5'd5); id_pc_src = 2'b01;
      cyc("mix0", MUL_ST, LU_ST);
      cyc("mix1", MUL_ST, LU_ST);
      cyc("mix2", LU_ST, LU_ST);
      ex_is_mul = 1'b0; ex_mem_read = 1'b0;
      cyc("mix3", FLUSH, FLUSH);
      idle();

      // Reset while in MUL_WAIT with cnt=1
      ex_is_mul = 1'b1;
      cyc("rmw0", MUL_ST, RUN_OK);
      ex_is_mul = 1'b0;
      #1;
      check("rmw_cnt1_L3", o3, MUL_ST);
      reset_n = 1'b0;
      #1;
      check("rmw_rst_L3", o3, RST_O);
      check("rmw_rst_L1", o1, RST_O);
      #1;
      reset_n = 1'b1;
      cyc("rmw_run0", RUN_OK, RUN_OK);
      cyc("rmw_run1", RUN_OK, RUN_OK);

      // Halt with redirect asserted: no flush, then halted for 100 cycles
      id_inst = mk(7'b1111111, 5'd0, 5'd0); id_pc_src = 2'b01;
      cyc("halt_det", HLT_1, HLT_1);
      id_inst = mk(7'b1100011, 5'd1, 5'd5);
      ex_mem_read = 1'b1; ex_rd = 5'd5; ex_is_mul = 1'b1;
      for (int i = 0; i < 100; i++)
         cyc("halted", HLT_O, HLT_O);

      // Reset while halted
      reset_n = 1'b0;
      #1;
      check("hrst_L3", o3, RST_O);
      check("hrst_L1", o1, RST_O);
      #1;
      reset_n = 1'b1;
      idle();
      cyc("hrst_run", RUN_OK, RUN_OK);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
